rvc_fetch_aligner: RTL and testbench

- Sits between the instruction-fetch stage and decode; acts as the IF/ID pipeline register for the RV32IC core.
- Consumes word-aligned 32-bit fetch words and realigns 16-bit compressed and 32-bit instructions, including 32-bit instructions that straddle two fetch words.
- Presents one instruction per cycle, with its PC, to decode.
- Back-pressures fetch when a word holds two instructions or when decode stalls.

---
 rtl/rvc_fetch_aligner.sv | 153 +++++++++++++++
 tb/tb_rvc_fetch_aligner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: IF/ID register that realigns 16/32-bit RV32IC instructions out of word fetches.
// Latency: one cycle from accepted fetch word to id_valid; RVC_ALIGN_ILLEGAL_EN adds the id_illegal flag.
// Backpressure: fetch_stall (combinational) holds fetch when a word carries two instructions or decode stalls.
module rvc_fetch_aligner #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [31:0]     fetch_instr,
    input  logic            fetch_valid,
    input  logic            flush,
    input  logic            id_stall,
    output logic            fetch_stall,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_compressed,
    output logic            id_valid
`ifdef RVC_ALIGN_ILLEGAL_EN
    ,
    output logic            id_illegal
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] UPPER = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [15:0]     hbuf;
    logic [XLEN-1:0] hpc;

    logic [15:0]     lo;
    logic [15:0]     hi;
    logic            lo_c;
    logic            hi_c;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] base_p2;

    logic            emit;
    logic            emit_c;
    logic [31:0]     emit_instr;
    logic [XLEN-1:0] emit_pc;
    logic            load_hbuf;
    logic            unused_pc_bit;

    assign lo            = fetch_instr[15:0];
    assign hi            = fetch_instr[31:16];
    assign lo_c          = (lo[1:0] != 2'b11);
    assign hi_c          = (hi[1:0] != 2'b11);
    assign base          = {fetch_pc[XLEN-1:2], 2'b00};
    assign base_p2       = base + {{(XLEN-2){1'b0}}, 2'b10};
    assign unused_pc_bit = fetch_pc[0];

    always_comb begin
        state_nxt  = state;
        emit       = 1'b0;
        emit_c     = 1'b0;
        emit_instr = NOP_INSTR;
        emit_pc    = base;
        load_hbuf  = 1'b0;
        if (fetch_valid) begin
            case (state)
                EMPTY: begin
                    if (!fetch_pc[1]) begin
                        emit    = 1'b1;
                        emit_pc = base;
                        if (!lo_c) begin
                            emit_instr = fetch_instr;
                        end else begin
                            emit_c     = 1'b1;
                            emit_instr = {16'h0000, lo};
                            if (hi_c) begin
                                state_nxt = UPPER;
                            end else begin
                                load_hbuf = 1'b1;
                                state_nxt = HALF;
                            end
                        end
                    end else if (hi_c) begin
                        // Jump target in the upper halfword: lo belongs to older code.
                        emit       = 1'b1;
                        emit_c     = 1'b1;
                        emit_instr = {16'h0000, hi};
                        emit_pc    = base_p2;
                    end else begin
                        load_hbuf = 1'b1;
                        state_nxt = HALF;
                    end
                end
                HALF: begin
                    emit       = 1'b1;
                    emit_instr = {lo, hbuf};
                    emit_pc    = hpc;
                    if (hi_c) begin
                        state_nxt = UPPER;
                    end else begin
                        load_hbuf = 1'b1;
                    end
                end
                UPPER: begin
                    if (hi_c) begin
                        emit       = 1'b1;
                        emit_c     = 1'b1;
                        emit_instr = {16'h0000, hi};
                        emit_pc    = base_p2;
                        state_nxt  = EMPTY;
                    end else begin
                        load_hbuf = 1'b1;
                        state_nxt = HALF;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign fetch_stall = id_stall | (!flush && (state_nxt == UPPER));

    // Flush leaves exactly the reset image so a redirect behaves like a fresh start.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            state         <= EMPTY;
            hbuf          <= 16'h0000;
            hpc           <= '0;
            id_valid      <= 1'b0;
            id_instr      <= NOP_INSTR;
            id_pc         <= '0;
            id_compressed <= 1'b0;
`ifdef RVC_ALIGN_ILLEGAL_EN
            id_illegal    <= 1'b0;
`endif
        end else if (!id_stall) begin
            state         <= state_nxt;
            if (load_hbuf) begin
                hbuf <= hi;
                hpc  <= base_p2;
            end
            id_valid      <= emit;
            id_instr      <= emit ? emit_instr : NOP_INSTR;
            id_compressed <= emit && emit_c;
            if (emit) begin
                id_pc <= emit_pc;
            end
`ifdef RVC_ALIGN_ILLEGAL_EN
            id_illegal    <= emit && emit_c && (emit_instr[15:0] == 16'h0000);
`endif
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Bench for rvc_fetch_aligner: directed walk through the alignment cases, then a random
// instruction stream fetched word by word and compared against the program it came from.
module tb_rvc_fetch_aligner;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] BASE  = 32'h00001000;
    localparam int          NPROG = 1500;
    localparam int          NMEM  = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_valid;
    logic        flush;
    logic        id_stall;
    logic        fetch_stall;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_compressed;
    logic        id_valid;
`ifdef RVC_ALIGN_ILLEGAL_EN
    logic        id_illegal;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int consumed    = 0;

    logic [15:0] mem [NMEM];
    logic [31:0] prog_instr [NPROG];
    logic [31:0] prog_pc [NPROG];
    logic        prog_c [NPROG];

    logic [31:0] fpc;
    logic [31:0] aligned;
    logic [31:0] pc;
    logic [31:0] w;
    logic [15:0] h;
    logic        held;
    int          exp_idx;
    int          jt;

    rvc_fetch_aligner dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_pc      (fetch_pc),
        .fetch_instr   (fetch_instr),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .id_stall      (id_stall),
        .fetch_stall   (fetch_stall),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_compressed (id_compressed),
        .id_valid      (id_valid)
`ifdef RVC_ALIGN_ILLEGAL_EN
        ,
        .id_illegal    (id_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] instr,
                           input logic [31:0] ipc, input logic c, input logic ill);
        chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
        chk({tag, ".instr"}, id_instr, instr);
        if (v) chk({tag, ".pc"}, id_pc, ipc);
        chk({tag, ".comp"}, {31'd0, id_compressed}, {31'd0, c});
`ifdef RVC_ALIGN_ILLEGAL_EN
        chk({tag, ".illegal"}, {31'd0, id_illegal}, {31'd0, ill});
`else
        if (ill && !c) $display("note: illegal flag requested on a non-compressed vector in %s", tag);
`endif
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, ".fstall"}, {31'd0, fetch_stall}, {31'd0, exp});
    endtask

    // Drive one cycle's inputs just after the rising edge, then park on the falling edge.
    task automatic cyc(input logic v, input logic [31:0] p, input logic [31:0] wd,
                       input logic fl, input logic st, input logic rst);
        @(posedge clk);
        #1;
        fetch_valid = v;
        fetch_pc    = p;
        fetch_instr = wd;
        flush       = fl;
        id_stall    = st;
        reset       = rst;
        @(negedge clk);
    endtask

    function automatic int hw_idx(input logic [31:0] a);
        return int'((a - BASE) >> 1);
    endfunction

    initial begin
        reset = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0;
        flush = 1'b0; id_stall = 1'b0;

        // Reset and the first full-width instruction.
        cyc(0, 32'h0, 32'h0, 0, 0, 0);
        cyc(0, 32'h0, 32'h0, 0, 0, 0);
        cyc(0, 32'h0, 32'h0, 0, 0, 0);
        chk_out("reset", 0, NOP, 32'h0, 0, 0);
        chk("reset.pc", id_pc, 32'h0);
        cyc(1, 32'h100, 32'h00A00093, 0, 0, 1);
        chk_out("first.pre", 0, NOP, 32'h0, 0, 0);
        cyc(1, 32'h104, 32'h40854505, 0, 0, 1);
        chk_out("full32", 1, 32'h00A00093, 32'h100, 0, 0);
        chk_stall("pair.lo", 1);

        // Two compressed in one word, then a straddling 32-bit instruction.
        cyc(1, 32'h104, 32'h40854505, 0, 0, 1);
        chk_out("pair.lo", 1, 32'h00004505, 32'h104, 1, 0);
        chk_stall("pair.hi", 0);
        cyc(1, 32'h108, 32'h00934505, 0, 0, 1);
        chk_out("pair.hi", 1, 32'h00004085, 32'h106, 1, 0);
        chk_stall("straddle.a", 0);
        cyc(1, 32'h10C, 32'h45050293, 0, 0, 1);
        chk_out("straddle.a", 1, 32'h00004505, 32'h108, 1, 0);
        chk_stall("straddle.b", 1);
        cyc(1, 32'h10C, 32'h45050293, 0, 0, 1);
        chk_out("straddle.b", 1, 32'h02930093, 32'h10A, 0, 0);
        chk_stall("upper", 0);
        cyc(1, 32'h110, 32'h00934505, 0, 0, 1);
        chk_out("upper", 1, 32'h00004505, 32'h10E, 1, 0);
        chk_stall("tohalf", 0);

        // Decode stall for four cycles while buffering a half instruction.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h114, 32'h00000293, 0, 1, 1);
            chk_out("stall.hold", 1, 32'h00004505, 32'h110, 1, 0);
            chk_stall("stall.hold", 1);
        end
        cyc(1, 32'h114, 32'h00000293, 0, 0, 1);
        chk_out("stall.release", 1, 32'h00004505, 32'h110, 1, 0);
        chk_stall("stall.release", 1);
        cyc(1, 32'h114, 32'h00000293, 0, 0, 1);
        chk_out("stall.resume", 1, 32'h02930093, 32'h112, 0, 0);
        chk_stall("stall.resume", 0);
        cyc(1, 32'h118, 32'h00930001, 0, 0, 1);
        chk_out("zero.hw", 1, 32'h00000000, 32'h116, 1, 1);
        chk_stall("half.again", 0);

        // Flush while HALF, then a jump into an upper halfword.
        cyc(1, 32'h11C, 32'hFFFFFFFF, 1, 0, 1);
        chk_out("preflush", 1, 32'h00000001, 32'h118, 1, 0);
        cyc(1, 32'h202, 32'h00004505, 0, 0, 1);
        chk_out("flush", 0, NOP, 32'h0, 0, 0);
        chk_stall("jump.hi", 0);
        cyc(0, 32'h0, 32'h0, 0, 0, 1);
        chk_out("jump.hi", 1, 32'h00000000, 32'h202, 1, 1);
        chk_stall("bubble", 0);

        // PC wrap at the top of the address space.
        cyc(1, 32'hFFFFFFFC, 32'h40854505, 0, 0, 1);
        chk_out("bubble", 0, NOP, 32'h0, 0, 0);
        chk_stall("wrap.lo", 1);
        cyc(1, 32'hFFFFFFFC, 32'h40854505, 0, 0, 1);
        chk_out("wrap.lo", 1, 32'h00004505, 32'hFFFFFFFC, 1, 0);
        cyc(1, 32'h200, 32'h40854505, 0, 0, 1);
        chk_out("wrap.hi", 1, 32'h00004085, 32'hFFFFFFFE, 1, 0);
        chk_stall("toupper", 1);

        // Reset while UPPER returns to EMPTY.
        cyc(1, 32'h200, 32'h40854505, 0, 0, 0);
        chk_out("rst.upper.pre", 1, 32'h00004505, 32'h200, 1, 0);
        cyc(0, 32'h0, 32'h0, 0, 0, 1);
        chk_out("rst.upper", 0, NOP, 32'h0, 0, 0);
        chk("rst.upper.pc", id_pc, 32'h0);
        chk_stall("rst.upper", 0);
        cyc(1, 32'h200, 32'h40854505, 0, 0, 1);
        chk_stall("rst.empty", 1);
        cyc(1, 32'h200, 32'h40854505, 0, 0, 1);
        chk_out("rst.empty", 1, 32'h00004505, 32'h200, 1, 0);
        chk_stall("rst.empty2", 0);

        // Random program: laid out in memory, fetched by a simple word-sequential fetch model.
        for (int i = 0; i < NMEM; i++) mem[i] = 16'h0001;
        pc = BASE + 32'($urandom_range(0, 1)) * 2;
        for (int i = 0; i < NPROG; i++) begin
            prog_pc[i] = pc;
            if ($urandom_range(0, 2) == 0) begin
                w = $urandom;
                w[1:0] = 2'b11;
                prog_instr[i] = w;
                prog_c[i] = 1'b0;
                mem[hw_idx(pc)]     = w[15:0];
                mem[hw_idx(pc + 2)] = w[31:16];
                pc = pc + 4;
            end else begin
                h = 16'($urandom);
                if (h[1:0] == 2'b11) h[1:0] = 2'b01;
                if ($urandom_range(0, 15) == 0) h = 16'h0000;
                prog_instr[i] = {16'h0000, h};
                prog_c[i] = 1'b1;
                mem[hw_idx(pc)] = h;
                pc = pc + 2;
            end
        end

        cyc(0, 32'h0, 32'h0, 1, 0, 1);
        fpc = prog_pc[0];
        exp_idx = 0;
        held = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            fetch_valid = held ? 1'b1 : ($urandom_range(0, 9) < 8);
            id_stall    = ($urandom_range(0, 99) < 15);
            flush       = ($urandom_range(0, 99) < 2);
            fetch_pc    = fpc;
            aligned     = {fpc[31:2], 2'b00};
            fetch_instr = {mem[hw_idx(aligned + 2)], mem[hw_idx(aligned)]};
            @(negedge clk);
            if (id_valid && !id_stall && !flush) begin
                chk("rand.instr", id_instr, prog_instr[exp_idx]);
                chk("rand.pc", id_pc, prog_pc[exp_idx]);
                chk("rand.comp", {31'd0, id_compressed}, {31'd0, prog_c[exp_idx]});
`ifdef RVC_ALIGN_ILLEGAL_EN
                chk("rand.illegal", {31'd0, id_illegal},
                    {31'd0, prog_c[exp_idx] && (prog_instr[exp_idx][15:0] == 16'h0000)});
`endif
                exp_idx++;
                consumed++;
            end
            if (flush) begin
                jt      = $urandom_range(0, NPROG / 4);
                fpc     = prog_pc[jt];
                exp_idx = jt;
                held    = 1'b0;
            end else if (fetch_valid && fetch_stall) begin
                held = 1'b1;
            end else begin
                held = 1'b0;
                if (fetch_valid) fpc = aligned + 4;
            end
        end
        chk("rand.progress", {31'd0, consumed >= 150}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
